// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader types and instruction memory geometry
package loader_pkg;

  localparam int          IMEM_AW   = 10;
  localparam int          INSTR_W   = 9;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_W_HI,
    S_W_LO,
    S_CHK,
    S_RUN,
    S_ERR
  } ld_state_t;

endpackage

// File: rtl/frame_csum.sv
// rtl/frame_csum.sv - running XOR of frame bytes with clear and enable
module frame_csum (
  input  logic       CLK,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)   csum <= 8'h00;
    else if (clr) csum <= 8'h00;
    else if (en)  csum <= csum ^ din;
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream writer for instruction memory
module prog_loader
  import loader_pkg::*;
#(
  parameter int         AW   = IMEM_AW,
  parameter int         IW   = INSTR_W,
  parameter logic [7:0] SYNC = SYNC_BYTE
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_start,
  output logic          done,
  output logic          err
);

  ld_state_t state_q, state_d;
  logic          rdy_q;
  logic [AW-1:0] len_q;
  logic [AW:0]   cnt_q, cnt_inc;
  logic          hi_q;
  logic          acc;
  logic          csum_clr, csum_en;
  logic [7:0]    csum;

  assign acc     = in_valid && rdy_q;
  assign cnt_inc = cnt_q + {{AW{1'b0}}, 1'b1};

  frame_csum u_csum (
    .CLK   (CLK),
    .reset (reset),
    .clr   (csum_clr),
    .en    (csum_en),
    .din   (in_data),
    .csum  (csum)
  );

  always_comb begin
    state_d  = state_q;
    csum_clr = 1'b0;
    csum_en  = 1'b0;
    if (acc) begin
      case (state_q)
        S_IDLE, S_RUN, S_ERR: begin
          // SYNC only resyncs between frames; inside a frame it is ordinary data
          if (in_data == SYNC) begin
            state_d  = S_LEN_HI;
            csum_clr = 1'b1;
          end
        end
        S_LEN_HI: begin
          csum_en = 1'b1;
          state_d = (|in_data[7:AW-8]) ? S_ERR : S_LEN_LO;
        end
        S_LEN_LO: begin
          csum_en = 1'b1;
          state_d = (|{len_q[AW-1:8], in_data}) ? S_W_HI : S_CHK;
        end
        S_W_HI: begin
          csum_en = 1'b1;
          state_d = (|in_data[7:1]) ? S_ERR : S_W_LO;
        end
        S_W_LO: begin
          csum_en = 1'b1;
          state_d = (cnt_inc == {1'b0, len_q}) ? S_CHK : S_W_HI;
        end
        S_CHK:   state_d = (in_data == csum) ? S_RUN : S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      wr_en   <= 1'b0;
      if (csum_clr) cnt_q <= '0;
      if (acc) begin
        case (state_q)
          S_LEN_HI: len_q[AW-1:8] <= in_data[AW-9:0];
          S_LEN_LO: len_q[7:0]    <= in_data;
          S_W_HI:   hi_q          <= in_data[0];
          S_W_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= cnt_q[AW-1:0];
            wr_data <= {hi_q, in_data};
            cnt_q   <= cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready   = rdy_q;
  assign core_start = (state_q != S_RUN);
  assign done       = (state_q == S_RUN);
  assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;
  import loader_pkg::*;

  logic       CLK;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  logic       core_start;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [9:0] q_addr[$];
  logic [8:0] q_data[$];

  prog_loader dut (
    .CLK        (CLK),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_start (core_start),
    .done       (done),
    .err        (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  function automatic logic [31:0] wq(input int i);
    if (i < q_addr.size()) return {13'd0, q_addr[i], q_data[i]};
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [7:0] c;
    logic [8:0] instr;
    int         bad;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge CLK);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    check("rst_wr", {21'd0, wr_en, wr_addr}, 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_flags", {29'd0, core_start, done, err}, 32'b100);
    reset = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    send(8'h12);
    check("idle_drop", 32'(dut.state_q), 32'(S_IDLE));

    // basic load: csum = 00^03^01^2F^00^40^01^FF = 93
    clear_q();
    send(8'hA5); send(8'h00); send(8'h03);
    send(8'h01); send(8'h2F); send(8'h00); send(8'h40); send(8'h01); send(8'hFF);
    check("basic_start_before_csum", 32'(core_start), 32'd1);
    send(8'h93);
    check("basic_start_fall", 32'(core_start), 32'd0);
    check("basic_done", 32'(done), 32'd1);
    check("basic_nwr", q_addr.size(), 32'd3);
    check("basic_w0", wq(0), {13'd0, 10'd0, 9'h12F});
    check("basic_w1", wq(1), {13'd0, 10'd1, 9'h040});
    check("basic_w2", wq(2), {13'd0, 10'd2, 9'h1FF});

    // reload from RUN, then bad checksum
    clear_q();
    send(8'hA5);
    check("reload_start_rise", {30'd0, core_start, done}, 32'b10);
    send(8'h00); send(8'h03);
    send(8'h01); send(8'h2F); send(8'h00); send(8'h40); send(8'h01); send(8'hFF);
    send(8'h92);
    check("badcs_err", 32'(err), 32'd1);
    check("badcs_hold", {30'd0, core_start, done}, 32'b10);
    check("badcs_nwr", q_addr.size(), 32'd3);
    check("badcs_w0_addr0", wq(0), {13'd0, 10'd0, 9'h12F});

    // good frame after error: 00^01^00^40 = 41
    clear_q();
    send(8'hA5);
    check("err_clear_on_sync", 32'(err), 32'd0);
    send(8'h00); send(8'h01); send(8'h00); send(8'h40); send(8'h41);
    check("recover_done", {29'd0, core_start, done, err}, 32'b010);
    check("recover_w0", wq(0), {13'd0, 10'd0, 9'h040});

    // empty program
    clear_q();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    check("empty_nwr", q_addr.size(), 32'd0);
    check("empty_done", 32'(done), 32'd1);

    // malformed word high byte
    clear_q();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h2F); send(8'h03);
    check("malformed_err", {29'd0, core_start, done, err}, 32'b101);
    send(8'h00);
    check("malformed_stays_err", 32'(dut.state_q), 32'(S_ERR));
    check("malformed_nwr", q_addr.size(), 32'd1);

    // A5 as data inside a word: 00^01^00^A5 = A4
    clear_q();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h00); send(8'hA5);
    check("sync_as_data_state", 32'(dut.state_q), 32'(S_CHK));
    send(8'hA4);
    check("sync_as_data_done", 32'(done), 32'd1);
    check("sync_as_data_w0", wq(0), {13'd0, 10'd0, 9'h0A5});

    // reset asserted while the W_LO byte is pending
    clear_q();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01);
    check("pre_reset_state", 32'(dut.state_q), 32'(S_W_LO));
    in_data  = 8'h2F;
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    check("async_rst_out", {30'd0, wr_en, core_start}, 32'b01);
    @(negedge CLK);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge CLK);
    check("async_rst_nwr", q_addr.size(), 32'd0);

    // stress: len 1023 with random gaps
    clear_q();
    send(8'hA5); send(8'h03); send(8'hFF);
    c = 8'h03 ^ 8'hFF;
    for (int i = 0; i < 1023; i++) begin
      instr = 9'((i * 37 + 5) & 9'h1FF);
      in_data = 8'hA5;
      repeat ($urandom_range(0, 1)) @(negedge CLK);
      send({7'd0, instr[8]});
      repeat ($urandom_range(0, 1)) @(negedge CLK);
      send(instr[7:0]);
      c = c ^ {7'd0, instr[8]} ^ instr[7:0];
    end
    send(c);
    check("stress_nwr", q_addr.size(), 32'd1023);
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      instr = 9'((i * 37 + 5) & 9'h1FF);
      if (q_addr[i] !== 10'(i) || q_data[i] !== instr) bad++;
    end
    check("stress_data", bad, 32'd0);
    check("stress_last_addr", (q_addr.size() > 0) ? 32'(q_addr[q_addr.size()-1]) : 32'hFFFF, 32'd1022);
    check("stress_done", {29'd0, core_start, done, err}, 32'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
